// File: rtl/pt_axi4_rd_splitter.sv
// AXI4 read-burst to AXI4-Lite single-beat splitter: one burst at a time,
// bounded Lite reads in flight, Lite responses forwarded upstream as one burst.
module pt_axi4_rd_splitter #(
    parameter int AXI_ADDR_W      = 32,
    parameter int DATA_W          = 64,
    parameter int ID_W            = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    output logic                  o_idle,
    input  logic [ID_W-1:0]       i_arid,
    input  logic [AXI_ADDR_W-1:0] i_araddr,
    input  logic [7:0]            i_arlen,
    input  logic [1:0]            i_arburst,
    input  logic                  i_arvalid,
    output logic                  o_arready,
    output logic [ID_W-1:0]       o_rid,
    output logic [DATA_W-1:0]     o_rdata,
    output logic [1:0]            o_rresp,
    output logic                  o_rlast,
    output logic                  o_rvalid,
    input  logic                  i_rready,
    output logic [AXI_ADDR_W-1:0] o_lite_araddr,
    output logic                  o_lite_arvalid,
    input  logic                  i_lite_arready,
    input  logic [DATA_W-1:0]     i_lite_rdata,
    input  logic [1:0]            i_lite_rresp,
    input  logic                  i_lite_rvalid,
    output logic                  o_lite_rready
);

    localparam int BEAT_BYTES = DATA_W / 8;
    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam int OUT_W      = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [AXI_ADDR_W-1:0] BEAT_MASK = AXI_ADDR_W'(BEAT_BYTES - 1);
    localparam logic [AXI_ADDR_W-1:0] BEAT_STEP = AXI_ADDR_W'(BEAT_BYTES);
    localparam logic [OUT_W-1:0]      OUT_MAX   = OUT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_arready;
    logic [ID_W-1:0]       r_id;
    logic [7:0]            r_len;
    logic                  r_fixed;
    logic                  r_wrap;
    logic [AXI_ADDR_W-1:0] r_addr;
    logic [7:0]            r_issue_cnt;
    logic [7:0]            r_ret_cnt;
    logic [OUT_W-1:0]      r_outstanding;

    logic                  w_active;
    logic                  w_lite_ar_hs;
    logic                  w_lite_r_hs;
    logic                  w_wrap_len;
    logic [AXI_ADDR_W-1:0] w_wrap_mask;
    logic [AXI_ADDR_W-1:0] w_incr_addr;
    logic [AXI_ADDR_W-1:0] w_next_addr;

    assign w_active     = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign w_lite_ar_hs = o_lite_arvalid && i_lite_arready;
    assign w_lite_r_hs  = i_lite_rvalid && o_lite_rready;

    // Only power-of-two beat counts wrap; anything else falls back to INCR.
    assign w_wrap_len = (i_arburst == 2'd2) &&
                        ((i_arlen == 8'd1) || (i_arlen == 8'd3) ||
                         (i_arlen == 8'd7) || (i_arlen == 8'd15));

    // With len+1 a power of two, (len+1)*BEAT_BYTES-1 is len shifted up with the beat bits set.
    assign w_wrap_mask = (AXI_ADDR_W'(r_len) << BEAT_SHIFT) | BEAT_MASK;
    assign w_incr_addr = r_addr + BEAT_STEP;
    assign w_next_addr = r_fixed ? r_addr :
                         r_wrap  ? ((r_addr & ~w_wrap_mask) | (w_incr_addr & w_wrap_mask)) :
                                   w_incr_addr;

    assign o_arready      = r_arready;
    assign o_idle         = r_arready && !i_arvalid;
    assign o_lite_araddr  = r_addr;
    assign o_lite_arvalid = (r_state == S_ISSUE) && (r_outstanding < OUT_MAX);
    assign o_lite_rready  = i_rready && w_active;
    assign o_rvalid       = i_lite_rvalid && w_active;
    assign o_rid          = r_id;
    assign o_rdata        = w_active ? i_lite_rdata : '0;
    assign o_rresp        = w_active ? i_lite_rresp : 2'd0;
    assign o_rlast        = w_active && (r_ret_cnt == r_len);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_arready     <= 1'b0;
            r_id          <= '0;
            r_len         <= '0;
            r_fixed       <= 1'b0;
            r_wrap        <= 1'b0;
            r_addr        <= '0;
            r_issue_cnt   <= '0;
            r_ret_cnt     <= '0;
            r_outstanding <= '0;
        end else begin
            if (w_lite_ar_hs && !w_lite_r_hs) begin
                r_outstanding <= r_outstanding + OUT_W'(1);
            end else if (!w_lite_ar_hs && w_lite_r_hs) begin
                r_outstanding <= r_outstanding - OUT_W'(1);
            end

            // NOTE: non-blocking assignments later in this block override earlier ones,
            // so the default r_arready<=1 below yields to the capture and final-beat cases.
            case (r_state)
                S_IDLE: begin
                    r_arready <= 1'b1;
                    if (i_arvalid && r_arready) begin
                        r_arready   <= 1'b0;
                        r_id        <= i_arid;
                        r_len       <= i_arlen;
                        r_fixed     <= (i_arburst == 2'd0);
                        r_wrap      <= w_wrap_len;
                        r_addr      <= i_araddr & ~BEAT_MASK;
                        r_issue_cnt <= '0;
                        r_ret_cnt   <= '0;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_lite_ar_hs) begin
                        r_addr      <= w_next_addr;
                        r_issue_cnt <= r_issue_cnt + 8'd1;
                        if (r_issue_cnt == r_len) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_lite_r_hs) begin
                r_ret_cnt <= r_ret_cnt + 8'd1;
                if (r_ret_cnt == r_len) begin
                    r_state   <= S_IDLE;
                    r_arready <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pt_axi4_rd_splitter.sv
// Randomized bench for pt_axi4_rd_splitter: a Lite slave model plus an upstream
// scoreboard whose addresses and beats come from a plain-arithmetic burst model.
module tb_pt_axi4_rd_splitter;

    localparam int AW   = 32;
    localparam int DW   = 64;
    localparam int IW   = 4;
    localparam int MAXO = 4;
    localparam int BEAT = DW / 8;

    logic            i_clk;
    logic            i_rst;
    logic            o_idle;
    logic [IW-1:0]   i_arid;
    logic [AW-1:0]   i_araddr;
    logic [7:0]      i_arlen;
    logic [1:0]      i_arburst;
    logic            i_arvalid;
    logic            o_arready;
    logic [IW-1:0]   o_rid;
    logic [DW-1:0]   o_rdata;
    logic [1:0]      o_rresp;
    logic            o_rlast;
    logic            o_rvalid;
    logic            i_rready;
    logic [AW-1:0]   o_lite_araddr;
    logic            o_lite_arvalid;
    logic            i_lite_arready;
    logic [DW-1:0]   i_lite_rdata;
    logic [1:0]      i_lite_rresp;
    logic            i_lite_rvalid;
    logic            o_lite_rready;

    pt_axi4_rd_splitter #(
        .AXI_ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .o_idle(o_idle),
        .i_arid(i_arid), .i_araddr(i_araddr), .i_arlen(i_arlen),
        .i_arburst(i_arburst), .i_arvalid(i_arvalid), .o_arready(o_arready),
        .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast),
        .o_rvalid(o_rvalid), .i_rready(i_rready),
        .o_lite_araddr(o_lite_araddr), .o_lite_arvalid(o_lite_arvalid),
        .i_lite_arready(i_lite_arready), .i_lite_rdata(i_lite_rdata),
        .i_lite_rresp(i_lite_rresp), .i_lite_rvalid(i_lite_rvalid),
        .o_lite_rready(o_lite_rready)
    );

    typedef struct {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [1:0]    burst;
        int            err_idx;
    } burst_t;

    typedef struct {
        logic [AW-1:0] addr;
        int            idx;
    } lite_t;

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
    } beat_t;

    burst_t        ar_q[$];
    logic [AW-1:0] exp_addr_q[$];
    lite_t         lite_q[$];
    beat_t         beat_q[$];

    int n_checks;
    int n_errors;
    int out_model;
    int lite_ar_idx;
    int cur_err_idx;
    int ret_budget;
    int ar_pct;
    int ret_pct;
    int rr_pct;
    int stall_left;
    int up_beats;
    int burst_ar_cnt;
    logic lite_r_hs_prev;
    logic chk_first_ar;
    logic chk_arready;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mkdata(input logic [AW-1:0] a, input int k);
        return {a, 24'hC0FFEE, 8'(k)};
    endfunction

    // Beat k address of a burst, straight from the burst-type rules.
    function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] a, input logic [7:0] len,
                                                 input logic [1:0] bt, input int k);
        logic [AW-1:0] start, size, base, off;
        start = a & ~AW'(BEAT - 1);
        if (bt == 2'd0) return start;
        if (bt == 2'd2 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
            size = (AW'(len) + 1) * AW'(BEAT);
            base = start - (start % size);
            off  = (start - base + AW'(k) * AW'(BEAT)) % size;
            return base + off;
        end
        return start + AW'(k) * AW'(BEAT);
    endfunction

    task automatic tick();
        logic          ar_hs, lar_hs, lr_hs, ur_hs;
        burst_t        b;
        beat_t         e;
        logic [AW-1:0] ea;
        @(negedge i_clk);
        if (ar_q.size() > 0) begin
            i_arvalid = 1'b1;
            i_arid    = ar_q[0].id;
            i_araddr  = ar_q[0].addr;
            i_arlen   = ar_q[0].len;
            i_arburst = ar_q[0].burst;
        end else begin
            i_arvalid = 1'b0;
        end
        if (!i_lite_rvalid || lite_r_hs_prev) begin
            if (lite_q.size() > 0 && ret_budget != 0 && $urandom_range(0, 99) < ret_pct) begin
                i_lite_rvalid = 1'b1;
                i_lite_rdata  = mkdata(lite_q[0].addr, lite_q[0].idx);
                i_lite_rresp  = (lite_q[0].idx == cur_err_idx) ? 2'd2 : 2'd0;
            end else begin
                i_lite_rvalid = 1'b0;
                i_lite_rdata  = {$urandom, $urandom};
                i_lite_rresp  = 2'($urandom_range(0, 3));
            end
        end
        i_lite_arready = ($urandom_range(0, 99) < ar_pct);
        if (stall_left > 0) begin
            i_rready = 1'b0;
            stall_left--;
        end else begin
            i_rready = ($urandom_range(0, 99) < rr_pct);
        end
        #1;
        if (chk_first_ar) begin
            check("first_lite_arvalid", o_lite_arvalid, 1);
            chk_first_ar = 1'b0;
        end
        if (chk_arready) begin
            check("arready_after_last", o_arready, 1);
            if (ar_q.size() == 0) check("idle_after_last", o_idle, 1);
            chk_arready = 1'b0;
        end
        ar_hs  = i_arvalid && o_arready;
        lar_hs = o_lite_arvalid && i_lite_arready;
        lr_hs  = i_lite_rvalid && o_lite_rready;
        ur_hs  = o_rvalid && i_rready;
        if (ar_hs) begin
            b = ar_q.pop_front();
            for (int k = 0; k <= int'(b.len); k++) begin
                ea = model_addr(b.addr, b.len, b.burst, k);
                exp_addr_q.push_back(ea);
                e.id   = b.id;
                e.data = mkdata(ea, k);
                e.resp = (k == b.err_idx) ? 2'd2 : 2'd0;
                e.last = (k == int'(b.len));
                beat_q.push_back(e);
            end
            cur_err_idx  = b.err_idx;
            lite_ar_idx  = 0;
            burst_ar_cnt = 0;
            up_beats     = 0;
            chk_first_ar = 1'b1;
        end
        if (lar_hs) begin
            check("outstanding_cap", (out_model < MAXO), 1);
            check("lite_ar_expected", (exp_addr_q.size() > 0), 1);
            if (exp_addr_q.size() > 0) check("lite_araddr", o_lite_araddr, exp_addr_q.pop_front());
            lite_q.push_back('{o_lite_araddr, lite_ar_idx});
            lite_ar_idx++;
            burst_ar_cnt++;
            out_model++;
        end
        if (lr_hs || ur_hs) check("r_hs_pair", ur_hs, lr_hs);
        if (lr_hs) begin
            if (lite_q.size() > 0) void'(lite_q.pop_front());
            out_model--;
            if (ret_budget > 0) ret_budget--;
        end
        if (ur_hs) begin
            check("beat_expected", (beat_q.size() > 0), 1);
            if (beat_q.size() > 0) begin
                e = beat_q.pop_front();
                check("rid", o_rid, e.id);
                check("rdata", o_rdata, e.data);
                check("rresp", o_rresp, e.resp);
                check("rlast", o_rlast, e.last);
                if (e.last) chk_arready = 1'b1;
            end
            up_beats++;
        end
        lite_r_hs_prev = lr_hs;
    endtask

    task automatic wait_done(input int bound, input string tag);
        int c;
        c = 0;
        while ((ar_q.size() > 0 || beat_q.size() > 0) && c < bound) begin
            tick();
            c++;
        end
        check(tag, (ar_q.size() == 0 && beat_q.size() == 0), 1);
        check({tag, "_addr_left"}, exp_addr_q.size(), 0);
        tick();
    endtask

    task automatic do_reset(input int hold);
        @(negedge i_clk);
        i_rst = 1'b1;
        ar_q.delete();
        exp_addr_q.delete();
        lite_q.delete();
        beat_q.delete();
        i_arvalid      = 1'b0;
        i_lite_rvalid  = 1'b0;
        i_lite_arready = 1'b0;
        i_rready       = 1'b1;
        i_lite_rdata   = {$urandom, $urandom};
        out_model      = 0;
        lite_r_hs_prev = 1'b0;
        chk_first_ar   = 1'b0;
        chk_arready    = 1'b0;
        stall_left     = 0;
        #1;
        check("rst_arready", o_arready, 0);
        check("rst_idle", o_idle, 0);
        check("rst_lite_arvalid", o_lite_arvalid, 0);
        check("rst_rvalid", o_rvalid, 0);
        check("rst_rlast", o_rlast, 0);
        check("rst_rdata", o_rdata, 0);
        check("rst_lite_araddr", o_lite_araddr, 0);
        check("rst_lite_rready", o_lite_rready, 0);
        repeat (hold) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        #1;
        check("post_rst_idle", o_idle, 1);
        check("post_rst_arready", o_arready, 1);
    endtask

    initial begin
        burst_t b;
        int     c;
        n_checks = 0; n_errors = 0; out_model = 0; lite_ar_idx = 0; cur_err_idx = -1;
        ret_budget = -1; ar_pct = 100; ret_pct = 100; rr_pct = 100; stall_left = 0;
        up_beats = 0; burst_ar_cnt = 0; lite_r_hs_prev = 1'b0;
        chk_first_ar = 1'b0; chk_arready = 1'b0;
        i_rst = 1'b0; i_arvalid = 1'b0; i_arid = '0; i_araddr = '0; i_arlen = '0;
        i_arburst = '0; i_rready = 1'b0; i_lite_arready = 1'b0; i_lite_rdata = '0;
        i_lite_rresp = '0; i_lite_rvalid = 1'b0;

        do_reset(2);

        ar_q.push_back('{4'd5, 32'h100, 8'd3, 2'd1, -1});
        wait_done(200, "incr_done");

        ar_q.push_back('{4'd1, 32'h118, 8'd3, 2'd2, -1});
        wait_done(200, "wrap_done");

        ar_q.push_back('{4'd2, 32'h40, 8'd2, 2'd0, -1});
        wait_done(200, "fixed_done");

        ret_budget = 0;
        ar_q.push_back('{4'd3, 32'h1000, 8'd7, 2'd1, -1});
        repeat (12) tick();
        check("max_out_ar_cnt", burst_ar_cnt, 4);
        check("max_out_arvalid", o_lite_arvalid, 0);
        ret_budget = 1;
        repeat (12) tick();
        check("max_out_ar_cnt_after_one", burst_ar_cnt, 5);
        check("max_out_arvalid_after_one", o_lite_arvalid, 0);
        ret_budget = -1;
        wait_done(300, "max_out_done");

        up_beats = 0;
        ar_q.push_back('{4'd7, 32'h200, 8'd3, 2'd1, 1});
        c = 0;
        while (up_beats < 1 && c < 100) begin
            tick();
            c++;
        end
        check("stall_reach_beat1", (up_beats >= 1), 1);
        stall_left = 5;
        repeat (5) begin
            tick();
            check("stall_rvalid", o_rvalid, 1);
            check("stall_lite_rready", o_lite_rready, 0);
            check("stall_rdata", o_rdata, mkdata(32'h208, 1));
            check("stall_rresp", o_rresp, 2);
        end
        wait_done(200, "stall_done");
        check("stall_beat_count", up_beats, 4);

        ar_q.push_back('{4'd3, 32'h103, 8'd1, 2'd1, -1});
        ar_q.push_back('{4'd9, 32'h300, 8'd0, 2'd1, -1});
        wait_done(200, "held_ar_done");

        ret_budget = 0;
        ar_q.push_back('{4'd4, 32'h500, 8'd7, 2'd1, -1});
        repeat (8) tick();
        do_reset(3);
        ret_budget = -1;
        ar_q.push_back('{4'd6, 32'h80, 8'd1, 2'd1, -1});
        wait_done(200, "post_reset_done");

        for (int n = 0; n < 40; n++) begin
            b.id    = IW'($urandom);
            b.addr  = $urandom;
            if ($urandom_range(0, 3) == 0) b.len = 8'($urandom_range(0, 40));
            else begin
                case ($urandom_range(0, 4))
                    0: b.len = 8'd0;
                    1: b.len = 8'd1;
                    2: b.len = 8'd3;
                    3: b.len = 8'd7;
                    default: b.len = 8'd15;
                endcase
            end
            b.burst   = 2'($urandom_range(0, 3));
            b.err_idx = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, int'(b.len))) : -1;
            ar_pct  = $urandom_range(20, 100);
            ret_pct = $urandom_range(20, 100);
            rr_pct  = $urandom_range(20, 100);
            ar_q.push_back(b);
            if ($urandom_range(0, 2) == 0) begin
                b.id   = b.id + 4'd1;
                b.addr = $urandom;
                ar_q.push_back(b);
            end
            wait_done(5000, "random_done");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pt_axi4_rd_splitter.md
Name: pt_axi4_rd_splitter

Overview:
Converts AXI4 read bursts with ID, LEN and BURST into single-beat AXI4-Lite reads for the AXI4-Lite register bridge, which sits directly downstream. Returns the Lite responses upstream as one AXI4 burst, with RID and RLAST added. It handles one burst at a time and caps the number of Lite reads in flight.

Parameters:
AXI_ADDR_W, 32, address width on both sides
DATA_W, 64, data width; BEAT_BYTES = DATA_W/8 (localparam)
ID_W, 4, AXI4 ID width
MAX_OUTSTANDING, 4, maximum Lite reads issued but not yet returned (range 1..15)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
o_idle  out  1  no burst active, nothing outstanding, no i_arvalid
i_arid  in  ID_W  burst ID
i_araddr  in  AXI_ADDR_W  burst start address
i_arlen  in  8  beats minus one
i_arburst  in  2  0=FIXED, 1=INCR, 2=WRAP
i_arvalid  in  1  AR valid
o_arready  out  1  AR ready
o_rid  out  ID_W  response ID
o_rdata  out  DATA_W  response data
o_rresp  out  2  response code
o_rlast  out  1  final beat of the burst
o_rvalid  out  1  R valid
i_rready  in  1  R ready
o_lite_araddr  out  AXI_ADDR_W  Lite read address
o_lite_arvalid  out  1  Lite AR valid
i_lite_arready  in  1  Lite AR ready
i_lite_rdata  in  DATA_W  Lite read data
i_lite_rresp  in  2  Lite response code
i_lite_rvalid  in  1  Lite R valid
o_lite_rready  out  1  Lite R ready

Behaviour:
- Reset values:
  - All outputs are 0 while i_rst is high.
  - o_idle becomes 1 on the first clock edge after reset deasserts.
  - o_arready becomes 1 on the first clock edge after reset deasserts.
  - Counters clear and state returns to IDLE.
  - Reset mid-burst abandons the burst; the downstream is reset in the same domain.
- States:
  - IDLE: o_arready=1. On AR handshake, capture id, len and burst. Capture the address aligned down to BEAT_BYTES. Move to ISSUE.
  - ISSUE: o_lite_arvalid = (outstanding < MAX_OUTSTANDING). Hold o_lite_araddr stable while arvalid && !arready. Each Lite AR handshake increments issue_cnt and steps the address. The handshake with issue_cnt==len moves to DRAIN.
  - DRAIN: o_lite_arvalid=0; wait for the final R handshake.
  - From ISSUE or DRAIN, the R handshake with ret_cnt==len moves to IDLE.
  - A new AR is accepted the cycle after the final R handshake.
- Latency: AR handshake in cycle N gives first o_lite_arvalid in cycle N+1.
- Address step:
  - FIXED: address unchanged.
  - INCR: address + BEAT_BYTES, modulo 2^AXI_ADDR_W.
  - WRAP: size = (len+1)*BEAT_BYTES; base = start & ~(size-1); next = base | ((addr+BEAT_BYTES) & (size-1)).
  - WRAP with len not in {1,3,7,15} is handled as INCR. Burst code 3 is handled as INCR.
- Outstanding counter:
  - +1 on a Lite AR handshake, -1 on a Lite R handshake; unchanged when both occur in the same cycle.
  - Never exceeds MAX_OUTSTANDING.
- R path is combinational pass-through:
  - o_rvalid = i_lite_rvalid && active.
  - o_lite_rready = i_rready && active.
  - o_rdata and o_rresp copy the Lite values; o_rid is the captured id; o_rlast = (ret_cnt==len).
  - ret_cnt increments on each R handshake.
  - "active" = state is ISSUE or DRAIN. Outside that, Lite R is neither forwarded nor accepted.
- Responses are passed per beat and never merged. A SLVERR on one beat does not abort the burst.
- o_rdata, o_rresp and o_rlast are stable while o_rvalid && !i_rready, given a stable Lite source.

Test Plan:
- INCR, len=3, addr 0x100, id 5 -> Lite addresses 0x100, 0x108, 0x110, 0x118; four R beats with rid=5; rlast high only on beat 4; o_idle returns to 1.
- WRAP, len=3, addr 0x118 -> Lite addresses 0x118, 0x100, 0x108, 0x110.
- FIXED, len=2, addr 0x40 -> three Lite reads, all at 0x40.
- MAX_OUTSTANDING=4, len=7, i_lite_rvalid held low -> exactly 4 Lite AR handshakes, then o_lite_arvalid=0; returning one R re-enables exactly one further AR.
- i_rready low for 5 cycles mid-burst, Lite returns SLVERR on beat 2 -> o_lite_rready low and o_rdata stable while stalled; o_rresp=2 on beat 2 only; burst completes with 4 beats.
- INCR, len=1, unaligned addr 0x103 -> Lite addresses 0x100, 0x108. Second AR held valid is accepted the cycle after the final R handshake. Reset asserted mid-burst -> o_arready=0 during reset; o_idle=1 one cycle after release.
